// File: rtl/mu0_mem.sv
// mu0_mem: 4096x16 wait-state memory for MU0 with a shared data bus and a program-load port
//   clk      : system clock, all state updates on the rising edge
//   reset    : synchronous active-high reset (array contents are kept)
//   addr     : word address, latched when an access starts
//   data     : shared bus; write data in, read data out while the read is complete
//   memrq    : access request, held high for the whole access
//   rnw      : 1 = read, 0 = write, latched with memrq
//   rdy      : access complete (high only in DONE)
//   ld_en    : program-load strobe, honoured only when idle with no request
//   ld_addr  : program-load address
//   ld_data  : program-load data
//   ld_err   : one-cycle pulse when a load strobe was rejected
//   acc_cnt  : saturating count of completed bus accesses
module mu0_mem #(
  parameter int unsigned WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] addr,
  inout  wire  [15:0] data,
  input  logic        memrq,
  input  logic        rnw,
  output logic        rdy,
  input  logic        ld_en,
  input  logic [11:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_err,
  output logic [15:0] acc_cnt
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [11:0] addr_q;
  logic rnw_q;
  logic [15:0] wdata_q;
  logic [15:0] rd_q;
  logic [15:0] acc_q;
  logic ld_err_q;
  logic [15:0] mem [4096];
  logic start;
  logic fire;
  logic ld_ok;
  logic mem_we;
  logic [11:0] mem_wa;
  logic [15:0] mem_wd;
  always_comb begin
    start = state_q == IDLE && memrq;
    // the access happens on the last BUSY edge, and only if the request is still held
    fire = state_q == BUSY && memrq && cnt_q == 4'd0;
    ld_ok = ld_en && state_q == IDLE && !memrq;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = memrq ? BUSY : IDLE;
        cnt_d = memrq ? 4'(WAIT) : cnt_q;
      end
      BUSY: begin
        state_d = !memrq ? IDLE : (cnt_q == 4'd0 ? DONE : BUSY);
        cnt_d = (memrq && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      end
      DONE: state_d = memrq ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    // loads and bus writes never coincide (loads need IDLE, bus writes need BUSY)
    mem_we = !reset && (ld_ok || (fire && !rnw_q));
    mem_wa = ld_ok ? ld_addr : addr_q;
    mem_wd = ld_ok ? ld_data : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      addr_q <= 12'd0;
      rnw_q <= 1'b0;
      wdata_q <= 16'd0;
      rd_q <= 16'd0;
      acc_q <= 16'd0;
      ld_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ld_err_q <= ld_en && !ld_ok;
      if (start) begin
        addr_q <= addr;
        rnw_q <= rnw;
        if (!rnw) wdata_q <= data;
      end
      if (fire && rnw_q) rd_q <= mem[addr_q];
      if (fire && acc_q != 16'hFFFF) acc_q <= acc_q + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end
  assign rdy = state_q == DONE;
  assign ld_err = ld_err_q;
  assign acc_cnt = acc_q;
  assign data = (state_q == DONE && rnw_q && memrq) ? rd_q : 16'bz;
endmodule

// File: tb/tb_mu0_mem.sv
// tb_mu0_mem: randomized self-checking bench for mu0_mem at WAIT = 0, 1 and 3
module tb_mu0_mem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] addr = 12'd0;
  logic [11:0] ld_addr = 12'd0;
  logic rnw = 1'b1;
  logic [2:0] memrq = 3'b0;
  logic [2:0] ld_en = 3'b0;
  logic [2:0] tb_oe = 3'b0;
  logic [2:0] rdy;
  logic [2:0] ld_err;
  logic [15:0] ld_data = 16'd0;
  logic [15:0] tb_dq = 16'd0;
  logic [15:0] acc [3];
  wire [15:0] bus0;
  wire [15:0] bus1;
  wire [15:0] bus2;
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] mdl [3][4096];
  int macc [3];
  always #5 clk = ~clk;
  assign bus0 = tb_oe[0] ? tb_dq : 16'bz;
  assign bus1 = tb_oe[1] ? tb_dq : 16'bz;
  assign bus2 = tb_oe[2] ? tb_dq : 16'bz;
  mu0_mem #(.WAIT(0)) u0 (.clk(clk), .reset(reset), .addr(addr), .data(bus0), .memrq(memrq[0]), .rnw(rnw),
    .rdy(rdy[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err[0]), .acc_cnt(acc[0]));
  mu0_mem #(.WAIT(1)) u1 (.clk(clk), .reset(reset), .addr(addr), .data(bus1), .memrq(memrq[1]), .rnw(rnw),
    .rdy(rdy[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err[1]), .acc_cnt(acc[1]));
  mu0_mem #(.WAIT(3)) u2 (.clk(clk), .reset(reset), .addr(addr), .data(bus2), .memrq(memrq[2]), .rnw(rnw),
    .rdy(rdy[2]), .ld_en(ld_en[2]), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err[2]), .acc_cnt(acc[2]));
  function automatic logic [15:0] bus(input int k);
    return k == 0 ? bus0 : (k == 1 ? bus1 : bus2);
  endfunction
  function automatic int wt(input int k);
    return k == 0 ? 0 : (k == 1 ? 1 : 3);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int k, input logic [11:0] a, input logic [15:0] d);
    ld_en[k] = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en[k] = 1'b0;
    mdl[k][a] = d;
    n_chk++;
    if (ld_err[k] !== 1'b0) $display("FAIL load_err k=%0d got %b want 0", k, ld_err[k]);
    else n_pass++;
  endtask
  task automatic access(input int k, input bit rd, input logic [11:0] a, input logic [15:0] wd, input bit with_ld);
    int n;
    logic [15:0] exp;
    addr = a;
    rnw = rd;
    memrq[k] = 1'b1;
    tb_dq = wd;
    tb_oe[k] = !rd;
    if (with_ld) begin
      ld_en[k] = 1'b1;
      ld_addr = a ^ 12'h010;
      ld_data = ~wd;
    end
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        if (with_ld) begin
          n_chk++;
          if (ld_err[k] !== 1'b1) $display("FAIL ld_conflict_pulse k=%0d got %b want 1", k, ld_err[k]);
          else n_pass++;
          ld_en[k] = 1'b0;
        end
        addr = 12'($urandom);
        rnw = 1'($urandom);
        tb_dq = 16'($urandom);
      end else if (n == 2 && with_ld) begin
        n_chk++;
        if (ld_err[k] !== 1'b0) $display("FAIL ld_conflict_clear k=%0d got %b want 0", k, ld_err[k]);
        else n_pass++;
      end
    end while (!rdy[k] && n < 40);
    n_chk++;
    if (n != wt(k) + 2) $display("FAIL latency k=%0d got %0d edges want %0d", k, n, wt(k) + 2);
    else n_pass++;
    if (rd) exp = mdl[k][a];
    else begin
      mdl[k][a] = wd;
      tb_dq = 16'd0;
      exp = 16'd0;
      #1;
    end
    n_chk++;
    if (bus(k) !== exp) $display("FAIL %s k=%0d addr=%h got %h want %h", rd ? "read_data" : "write_hiz", k, a, bus(k), exp);
    else n_pass++;
    macc[k] = macc[k] < 65535 ? macc[k] + 1 : macc[k];
    n_chk++;
    if (acc[k] !== 16'(macc[k])) $display("FAIL acc_cnt k=%0d got %0d want %0d", k, acc[k], macc[k]);
    else n_pass++;
    repeat ($urandom_range(0, 2)) tick();
    n_chk++;
    if (rdy[k] !== 1'b1) $display("FAIL done_hold k=%0d got %b want 1", k, rdy[k]);
    else n_pass++;
    memrq[k] = 1'b0;
    tb_oe[k] = 1'b1;
    tb_dq = 16'd0;
    #1;
    n_chk++;
    if (bus(k) !== 16'd0) $display("FAIL hiz_no_req k=%0d got %h want 0000", k, bus(k));
    else n_pass++;
    tb_oe[k] = 1'b0;
    tick();
    n_chk++;
    if (rdy[k] !== 1'b0) $display("FAIL rdy_release k=%0d got %b want 0", k, rdy[k]);
    else n_pass++;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    tb_oe = 3'b111;
    tb_dq = 16'd0;
    #1;
    n_chk++;
    if (rdy !== 3'b000) $display("FAIL reset_rdy got %b want 000", rdy);
    else n_pass++;
    n_chk++;
    if (ld_err !== 3'b000) $display("FAIL reset_ld_err got %b want 000", ld_err);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      n_chk++;
      if (acc[k] !== 16'd0) $display("FAIL reset_acc k=%0d got %0d want 0", k, acc[k]);
      else n_pass++;
      n_chk++;
      if (bus(k) !== 16'd0) $display("FAIL reset_hiz k=%0d got %h want 0000", k, bus(k));
      else n_pass++;
    end
    tb_oe = 3'b000;
    reset = 1'b0;
    tick();
  endtask
  task automatic test_prefill;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 64; a++) load(k, 12'(a), 16'($urandom));
  endtask
  task automatic test_load_read;
    load(1, 12'h005, 16'h1234);
    access(1, 1'b1, 12'h005, 16'd0, 1'b0);
  endtask
  task automatic test_write_read;
    access(1, 1'b0, 12'hFFF, 16'hBEEF, 1'b0);
    access(1, 1'b1, 12'hFFF, 16'd0, 1'b0);
  endtask
  task automatic test_ld_conflict;
    access(1, 1'b1, 12'h005, 16'h5A5A, 1'b1);
    access(1, 1'b1, 12'h015, 16'd0, 1'b0);
  endtask
  task automatic test_abort;
    logic seen;
    addr = 12'h020;
    rnw = 1'b0;
    memrq[2] = 1'b1;
    tb_oe[2] = 1'b1;
    tb_dq = ~mdl[2][12'h020];
    tick();
    tick();
    ld_en[2] = 1'b1;
    ld_addr = 12'h01E;
    ld_data = ~mdl[2][12'h01E];
    tick();
    n_chk++;
    if (ld_err[2] !== 1'b1) $display("FAIL ld_busy_pulse got %b want 1", ld_err[2]);
    else n_pass++;
    ld_en[2] = 1'b0;
    memrq[2] = 1'b0;
    tb_oe[2] = 1'b0;
    seen = rdy[2];
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | rdy[2];
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL abort_rdy got %b want 0", seen);
    else n_pass++;
    n_chk++;
    if (acc[2] !== 16'(macc[2])) $display("FAIL abort_acc got %0d want %0d", acc[2], macc[2]);
    else n_pass++;
    access(2, 1'b1, 12'h020, 16'd0, 1'b0);
    access(2, 1'b1, 12'h01E, 16'd0, 1'b0);
  endtask
  task automatic test_reset_busy;
    addr = 12'h021;
    rnw = 1'b0;
    memrq[2] = 1'b1;
    tb_oe[2] = 1'b1;
    tb_dq = ~mdl[2][12'h021];
    tick();
    tick();
    reset = 1'b1;
    memrq[2] = 1'b0;
    tb_oe[2] = 1'b0;
    ld_en[0] = 1'b1;
    ld_addr = 12'h002;
    ld_data = ~mdl[0][12'h002];
    tick();
    n_chk++;
    if (rdy !== 3'b000) $display("FAIL rst_busy_rdy got %b want 000", rdy);
    else n_pass++;
    n_chk++;
    if (ld_err !== 3'b000) $display("FAIL rst_ld_err got %b want 000", ld_err);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      n_chk++;
      if (acc[k] !== 16'd0) $display("FAIL rst_busy_acc k=%0d got %0d want 0", k, acc[k]);
      else n_pass++;
    end
    reset = 1'b0;
    ld_en[0] = 1'b0;
    tick();
    access(2, 1'b1, 12'h021, 16'd0, 1'b0);
    access(2, 1'b1, 12'h003, 16'd0, 1'b0);
    access(0, 1'b1, 12'h002, 16'd0, 1'b0);
  endtask
  task automatic test_back_to_back;
    access(0, 1'b1, 12'h000, 16'd0, 1'b0);
    access(0, 1'b1, 12'h001, 16'd0, 1'b0);
  endtask
  task automatic test_random;
    int k;
    int op;
    logic [11:0] a;
    logic [15:0] d;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      op = $urandom_range(0, 2);
      a = 12'($urandom_range(0, 63));
      d = 16'($urandom);
      if (op == 0) load(k, a, d);
      else access(k, op == 1, a, d, 1'b0);
    end
  endtask
  initial begin
    test_reset();
    test_prefill();
    test_load_read();
    test_write_read();
    test_ld_conflict();
    test_abort();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mu0_mem.md
MU0_MEM -- requirements
Module: mu0_mem

Interface
REQ-001 SHALL have parameter WAIT, default 1, meaning wait-state cycles inserted before each access (legal 0..15).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port addr  input  12  word address from the initiator.
REQ-005 SHALL have port data  inout  16  shared bus: write data in, read data out.
REQ-006 SHALL have port memrq  input  1  access request; held high for the whole access.
REQ-007 SHALL have port rnw  input  1  1 = read, 0 = write; sampled with memrq.
REQ-008 SHALL have port rdy  output  1  access complete; read data valid or write committed.
REQ-009 SHALL have port ld_en  input  1  program-load write strobe.
REQ-010 SHALL have port ld_addr  input  12  program-load address.
REQ-011 SHALL have port ld_data  input  16  program-load data.
REQ-012 SHALL have port ld_err  output  1  one-cycle pulse: load strobe rejected.
REQ-013 SHALL have port acc_cnt  output  16  count of completed bus accesses.

Function
REQ-014 SHALL contain a 4096 x 16 storage array with synchronous write and registered read.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE: memrq=1 at an edge SHALL latch addr, rnw and data (if rnw=0), load wait counter with WAIT, and move to BUSY.
REQ-017 BUSY with counter != 0 SHALL decrement the counter and stay in BUSY.
REQ-018 BUSY with counter == 0 SHALL perform the access on the latched address (read into the read register, or write latched data) and move to DONE.
REQ-019 rdy SHALL be 1 only in DONE; first rdy cycle is WAIT+2 edges after the edge sampling memrq in IDLE.
REQ-020 DONE SHALL hold while memrq=1 and move to IDLE on the edge memrq is sampled 0.
REQ-021 acc_cnt SHALL increment once per BUSY->DONE transition and saturate at 0xFFFF.
REQ-022 data SHALL be driven with the read register only when state=DONE, latched rnw=1 and memrq=1; otherwise data SHALL be high-Z.
REQ-023 Changes on addr, rnw or data after the latching edge SHALL NOT affect the access in progress.
REQ-024 memrq sampled 0 in BUSY SHALL abort: no write, no count increment, next state IDLE, rdy stays 0.
REQ-025 ld_en SHALL write ld_data to ld_addr only when state=IDLE and memrq=0 on the same edge.
REQ-026 ld_en in any other condition, including simultaneously with memrq in IDLE, SHALL be ignored and SHALL pulse ld_err for one cycle; memrq takes precedence.
REQ-027 WAIT=0 SHALL give a single BUSY cycle; wait counter SHALL be 4 bits wide.

Reset
REQ-028 reset=1 at an edge SHALL force state IDLE, rdy=0, ld_err=0, acc_cnt=0, wait counter=0 and read register=0, and data high-Z.
REQ-029 reset during BUSY SHALL discard the pending access; no write occurs.
REQ-030 reset SHALL NOT clear array contents; ld_en during reset SHALL be ignored without an ld_err pulse.

Verification
REQ-031 Load 0x1234 to 0x005 via ld_en; WAIT=1; read addr 0x005 -> rdy high 3 edges after request, data=0x1234, acc_cnt=1.
REQ-032 Write 0xBEEF to 0xFFF, drop memrq, read 0xFFF -> data=0xBEEF; the bus is high-Z during the write and during idle.
REQ-033 Raise ld_en and memrq on the same IDLE edge -> ld_err pulse for 1 cycle, load not written, and the bus access completes normally.
REQ-034 Write request with memrq dropped in BUSY (WAIT=3) -> target word unchanged, acc_cnt unchanged, rdy never asserted.
REQ-035 Assert reset in BUSY during a write -> state IDLE, rdy=0, acc_cnt=0, word unchanged, and previously loaded words still readable.
REQ-036 WAIT=0 back-to-back reads of 0x000 and 0x001 -> rdy 2 edges after each request and a correct word for each read.
